// File: rtl/sig_lvl_ctrl.sv
// sig_lvl_ctrl: per-channel polarity-aware level controller driven by
// assert/deassert/toggle/timed-pulse commands over a valid/ready port.
module sig_lvl_ctrl #(
    parameter int                    P_CHANNELS    = 4,
    parameter logic [P_CHANNELS-1:0] P_ACTIVE_HIGH = '1,
    parameter int                    P_CNT_W       = 16,
    localparam int CH_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [CH_W-1:0]       i_cmd_ch,
    input  logic [1:0]            i_cmd_op,
    input  logic [P_CNT_W-1:0]    i_cmd_len,
    output logic [P_CHANNELS-1:0] o_sig,
    output logic [P_CHANNELS-1:0] o_busy,
    output logic                  o_err
);

    if (P_CHANNELS < 1 || P_CHANNELS > 32) begin : g_bad_channels
        $error("sig_lvl_ctrl: P_CHANNELS must be within 1..32");
    end
    if (P_CNT_W < 1) begin : g_bad_cnt_w
        $error("sig_lvl_ctrl: P_CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_OFF,
        S_ON,
        S_PULSE
    } state_t;

    localparam logic [1:0] OP_DEASSERT = 2'b00;
    localparam logic [1:0] OP_ASSERT   = 2'b01;
    localparam logic [1:0] OP_PULSE    = 2'b10;

    state_t             st      [P_CHANNELS];
    state_t             st_nxt  [P_CHANNELS];
    logic [P_CNT_W-1:0] cnt     [P_CHANNELS];
    logic [P_CNT_W-1:0] cnt_nxt [P_CHANNELS];

    logic                  ch_ok;
    logic                  tgt_pulse;
    logic                  accept;
    logic                  illegal;
    logic                  go;
    logic [P_CHANNELS-1:0] hit;
    logic [P_CHANNELS-1:0] act_nxt;
    logic [P_CHANNELS-1:0] busy_nxt;

    always_comb begin
        ch_ok     = 32'(i_cmd_ch) < 32'(P_CHANNELS);
        tgt_pulse = 1'b0;
        hit       = '0;
        for (int i = 0; i < P_CHANNELS; i++) begin
            if (i_cmd_ch == CH_W'(i)) begin
                hit[i] = 1'b1;
                if (st[i] == S_PULSE) tgt_pulse = 1'b1;
            end
        end

        // Only an abort may interrupt a running pulse.
        o_cmd_ready = !(tgt_pulse && i_cmd_op != OP_DEASSERT);
        accept      = i_cmd_valid && o_cmd_ready;
        illegal     = !ch_ok || (i_cmd_op == OP_PULSE && i_cmd_len == '0);
        go          = accept && !illegal;

        for (int i = 0; i < P_CHANNELS; i++) begin
            st_nxt[i]  = st[i];
            cnt_nxt[i] = cnt[i];
            if (st[i] == S_PULSE) begin
                if ((go && hit[i] && i_cmd_op == OP_DEASSERT) ||
                    cnt[i] == P_CNT_W'(1)) begin
                    st_nxt[i]  = S_OFF;
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] - P_CNT_W'(1);
                end
            end else if (go && hit[i]) begin
                unique case (i_cmd_op)
                    OP_DEASSERT: st_nxt[i] = S_OFF;
                    OP_ASSERT:   st_nxt[i] = S_ON;
                    OP_PULSE: begin
                        st_nxt[i]  = S_PULSE;
                        cnt_nxt[i] = i_cmd_len;
                    end
                    default:
                        st_nxt[i] = (st[i] == S_ON) ? S_OFF : S_ON;
                endcase
            end
            act_nxt[i]  = st_nxt[i] != S_OFF;
            busy_nxt[i] = st_nxt[i] == S_PULSE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_CHANNELS; i++) begin
                st[i]  <= S_OFF;
                cnt[i] <= '0;
            end
            o_sig  <= ~P_ACTIVE_HIGH;
            o_busy <= '0;
            o_err  <= 1'b0;
        end else begin
            for (int i = 0; i < P_CHANNELS; i++) begin
                st[i]  <= st_nxt[i];
                cnt[i] <= cnt_nxt[i];
            end
            o_sig  <= act_nxt ~^ P_ACTIVE_HIGH;
            o_busy <= busy_nxt;
            o_err  <= accept && illegal;
        end
    end

endmodule

// File: tb/tb_sig_lvl_ctrl.sv
`timescale 1ns/1ps
// tb_sig_lvl_ctrl: directed vector table plus random traffic checked
// against a model that tracks each pulse by its last active cycle.
module tb_sig_lvl_ctrl;

    localparam logic [3:0] POL  = 4'b0101;
    localparam logic [2:0] POL3 = 3'b101;
    localparam logic [1:0] OP_D = 2'd0;
    localparam logic [1:0] OP_A = 2'd1;
    localparam logic [1:0] OP_P = 2'd2;
    localparam logic [1:0] OP_T = 2'd3;

    typedef struct {
        bit         v;
        logic [1:0] ch;
        logic [1:0] op;
        logic [15:0] len;
        logic       rdy;
        logic [3:0] sig;
        logic [3:0] busy;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ch = '0;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_len = '0;
    logic [3:0]  sig;
    logic [3:0]  busy;
    logic        err;

    logic        v3 = 1'b0;
    logic        rdy3;
    logic [1:0]  ch3 = '0;
    logic [1:0]  op3 = '0;
    logic [15:0] len3 = '0;
    logic [2:0]  sig3;
    logic [2:0]  busy3;
    logic        err3;

    int     errors = 0;
    int     checks = 0;
    bit     on_m   [4];
    longint pend_m [4];
    longint cyc = 0;
    bit     err_m = 1'b0;

    always #5 clk = ~clk;

    sig_lvl_ctrl #(
        .P_CHANNELS   (4),
        .P_ACTIVE_HIGH(POL),
        .P_CNT_W      (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_ch   (cmd_ch),
        .i_cmd_op   (cmd_op),
        .i_cmd_len  (cmd_len),
        .o_sig      (sig),
        .o_busy     (busy),
        .o_err      (err)
    );

    sig_lvl_ctrl #(
        .P_CHANNELS   (3),
        .P_ACTIVE_HIGH(POL3),
        .P_CNT_W      (16)
    ) dut3 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(v3),
        .o_cmd_ready(rdy3),
        .i_cmd_ch   (ch3),
        .i_cmd_op   (op3),
        .i_cmd_len  (len3),
        .o_sig      (sig3),
        .o_busy     (busy3),
        .o_err      (err3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            on_m[i]   = 1'b0;
            pend_m[i] = -1;
        end
        err_m = 1'b0;
    endtask

    function automatic bit pulsing(input int c);
        return pend_m[c] >= cyc;
    endfunction

    function automatic logic [3:0] exp_sig();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (on_m[i] || pend_m[i] >= cyc) ~^ POL[i];
        return r;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = pend_m[i] >= cyc;
        return r;
    endfunction

    // One clock of the main DUT; called and returning at a falling edge.
    task automatic cycle(input bit v, input logic [1:0] ch,
                         input logic [1:0] op, input logic [15:0] len,
                         output bit acc, output logic rdy);
        bit rdy_m;
        cmd_valid = v;
        cmd_ch    = ch;
        cmd_op    = op;
        cmd_len   = len;
        #1;
        rdy   = cmd_ready;
        rdy_m = !(pulsing(int'(ch)) && op != OP_D);
        chk("ready", 32'(rdy), 32'(rdy_m));
        acc = v && rdy_m;
        @(posedge clk);
        err_m = acc && op == OP_P && len == 16'd0;
        if (acc && !err_m) begin
            case (op)
                OP_D: begin
                    on_m[ch]   = 1'b0;
                    pend_m[ch] = -1;
                end
                OP_A: on_m[ch] = 1'b1;
                OP_P: begin
                    on_m[ch]   = 1'b0;
                    pend_m[ch] = cyc + longint'(len);
                end
                default: on_m[ch] = !on_m[ch];
            endcase
        end
        cyc++;
        @(negedge clk);
        chk("sig", 32'(sig), 32'(exp_sig()));
        chk("busy", 32'(busy), 32'(exp_busy()));
        chk("err", 32'(err), 32'(err_m));
    endtask

    task automatic cmd3(input bit v, input logic [1:0] ch,
                        input logic [1:0] op, input logic [15:0] len,
                        output logic rdy);
        v3   = v;
        ch3  = ch;
        op3  = op;
        len3 = len;
        #1;
        rdy = rdy3;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[$];
        bit          acc;
        logic        rs;
        bit          hold;
        bit          rv;
        logic [1:0]  rch;
        logic [1:0]  rop;
        logic [15:0] rlen;

        tbl.push_back('{1'b1, 2'd1, OP_A, 16'd0, 1'b1, 4'b1000, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd1, OP_T, 16'd0, 1'b1, 4'b1010, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd2, OP_D, 16'd0, 1'b1, 4'b1010, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd5, 1'b1, 4'b1011, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 2'd2, OP_A, 16'd0, 1'b1, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd3, 1'b0, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd3, 1'b0, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd3, 1'b0, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd3, 1'b0, 4'b1110, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd0, OP_P, 16'd3, 1'b1, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 2'd0, OP_D, 16'd0, 1'b1, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 2'd0, OP_D, 16'd0, 1'b1, 4'b1111, 4'b0001, 1'b0});
        tbl.push_back('{1'b0, 2'd0, OP_D, 16'd0, 1'b1, 4'b1110, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd1, OP_P, 16'd0, 1'b1, 4'b1110, 4'b0000, 1'b1});
        tbl.push_back('{1'b0, 2'd0, OP_D, 16'd0, 1'b1, 4'b1110, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 2'd2, OP_D, 16'd0, 1'b1, 4'b1010, 4'b0000, 1'b0});

        model_reset();

        // Held in reset
        @(negedge clk);
        chk("rst_sig", 32'(sig), 32'(4'b1010));
        chk("rst_busy", 32'(busy), 32'(4'b0000));
        chk("rst_err", 32'(err), 32'(1'b0));
        chk("rst_ready", 32'(cmd_ready), 32'(1'b1));
        chk("rst_sig3", 32'(sig3), 32'(3'b010));
        rst_n = 1'b1;

        // Three-channel instance: illegal channel and zero-length pulse
        cmd3(1'b1, 2'd3, OP_A, 16'd0, rs);
        chk("d3_badch_ready", 32'(rs), 32'(1'b1));
        chk("d3_badch_err", 32'(err3), 32'(1'b1));
        chk("d3_badch_sig", 32'(sig3), 32'(3'b010));
        cmd3(1'b0, 2'd0, OP_D, 16'd0, rs);
        chk("d3_err_drop", 32'(err3), 32'(1'b0));
        cmd3(1'b1, 2'd0, OP_P, 16'd0, rs);
        chk("d3_len0_err", 32'(err3), 32'(1'b1));
        chk("d3_len0_busy", 32'(busy3), 32'(3'b000));
        cmd3(1'b0, 2'd0, OP_D, 16'd0, rs);
        chk("d3_len0_drop", 32'(err3), 32'(1'b0));
        cmd3(1'b1, 2'd2, OP_A, 16'd0, rs);
        chk("d3_assert_sig", 32'(sig3), 32'(3'b110));
        chk("d3_assert_err", 32'(err3), 32'(1'b0));

        foreach (tbl[k]) begin
            cycle(tbl[k].v, tbl[k].ch, tbl[k].op, tbl[k].len, acc, rs);
            chk($sformatf("tbl%0d_ready", k), 32'(rs), 32'(tbl[k].rdy));
            chk($sformatf("tbl%0d_sig", k), 32'(sig), 32'(tbl[k].sig));
            chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
            chk($sformatf("tbl%0d_err", k), 32'(err), 32'(tbl[k].err));
        end

        // Long pulse on ch3 aborted after ten cycles
        cycle(1'b1, 2'd3, OP_P, 16'd100, acc, rs);
        chk("abort_start_busy", 32'(busy[3]), 32'(1'b1));
        chk("abort_start_sig", 32'(sig[3]), 32'(1'b0));
        repeat (9) cycle(1'b0, 2'd0, OP_D, 16'd0, acc, rs);
        cycle(1'b1, 2'd3, OP_D, 16'd0, acc, rs);
        chk("abort_ready", 32'(rs), 32'(1'b1));
        chk("abort_sig", 32'(sig[3]), 32'(1'b1));
        chk("abort_busy", 32'(busy[3]), 32'(1'b0));

        // Reset dropped in the middle of a maximum-length pulse
        cycle(1'b1, 2'd0, OP_P, 16'hFFFF, acc, rs);
        repeat (199) cycle(1'b0, 2'd0, OP_D, 16'd0, acc, rs);
        chk("long_busy", 32'(busy[0]), 32'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sig", 32'(sig), 32'(4'b1010));
        chk("async_rst_busy", 32'(busy), 32'(4'b0000));
        chk("async_rst_err", 32'(err), 32'(1'b0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_sig", 32'(sig), 32'(4'b1010));
        rst_n = 1'b1;
        cycle(1'b1, 2'd0, OP_A, 16'd0, acc, rs);
        chk("post_rst_assert", 32'(sig), 32'(4'b1011));
        cycle(1'b1, 2'd0, OP_D, 16'd0, acc, rs);

        // Random traffic; blocked commands are held until accepted
        hold = 1'b0;
        rv   = 1'b0;
        rch  = '0;
        rop  = '0;
        rlen = '0;
        for (int k = 0; k < 600; k++) begin
            if (!hold) begin
                rv   = $urandom_range(0, 3) != 0;
                rch  = 2'($urandom_range(0, 3));
                rop  = 2'($urandom_range(0, 3));
                rlen = ($urandom_range(0, 9) == 0) ? 16'd0
                                                   : 16'($urandom_range(1, 12));
            end
            cycle(rv, rch, rop, rlen, acc, rs);
            hold = rv && !acc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sig_lvl_ctrl.md
Name: sig_lvl_ctrl

Overview:
- Multi-channel, polarity-aware signal level controller.
- Each channel drives one output pin whose active level ("HIGH" or "LOW") is fixed per channel at elaboration.
- Accepts commands over a valid/ready interface: assert, deassert, toggle, or assert for a fixed number of cycles (timed pulse).
- Sits between control/sequencing logic and board-level enables, resets and strobes. Callers work only in logical active/inactive terms, never in pin polarity.

Parameters:
- P_CHANNELS, 4: number of channels; legal range 1..32, enforced by an elaboration-time check.
- P_ACTIVE_HIGH, all ones (P_CHANNELS bits): per-channel polarity. Bit i = 1 means channel i is active-HIGH; bit i = 0 means active-LOW.
- P_CNT_W, 16: width of the pulse-length field and of each per-channel counter; must be >= 1.
- Derived constant CH_W = max(1, $clog2(P_CHANNELS)).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command can be accepted this cycle.
- i_cmd_ch  in  CH_W  target channel index.
- i_cmd_op  in  2  operation: 00 DEASSERT, 01 ASSERT, 10 PULSE, 11 TOGGLE.
- i_cmd_len  in  P_CNT_W  pulse length in cycles; used only by PULSE.
- o_sig  out  P_CHANNELS  physical output levels, polarity already applied.
- o_busy  out  P_CHANNELS  bit i high while channel i is in the PULSE state.
- o_err  out  1  one-cycle strobe on acceptance of an illegal command.

Behaviour:
- Reset (asynchronous assert, synchronous release on i_clk):
  - every channel in state OFF, all counters 0;
  - o_sig = ~P_ACTIVE_HIGH, i.e. each pin at its inactive level;
  - o_busy = 0, o_err = 0.
- Physical output: o_sig[i] = active_i XNOR P_ACTIVE_HIGH[i], where active_i is 1 in states ON and PULSE.
- Outputs are registered. A command accepted in cycle t is visible on o_sig/o_busy in cycle t+1.
- Handshake:
  - A command is accepted when i_cmd_valid && o_cmd_ready at the clock edge.
  - o_cmd_ready is combinational: 0 only when the addressed channel is in PULSE and i_cmd_op != DEASSERT; otherwise 1.
  - i_cmd_ch, i_cmd_op and i_cmd_len must be held stable while valid is high and ready is low.
- Illegal commands (accepted, no state change, o_err = 1 for exactly the following cycle):
  - i_cmd_ch >= P_CHANNELS;
  - PULSE with i_cmd_len = 0.
- Per-channel FSM, states OFF, ON, PULSE:
  - OFF: ASSERT -> ON; TOGGLE -> ON; DEASSERT -> OFF (no-op, no error); PULSE(N) -> PULSE with counter = N.
  - ON: DEASSERT -> OFF; TOGGLE -> OFF; ASSERT -> ON (no-op); PULSE(N) -> PULSE with counter = N. The output stays active throughout, and the channel ends OFF.
  - PULSE: counter decrements every cycle. When the counter is 1, the next state is OFF. DEASSERT -> OFF immediately (abort). Other ops are blocked by ready = 0.
- Pulse length: PULSE(N) accepted at cycle t gives an active output in cycles t+1 .. t+N (exactly N cycles), with o_busy high over the same cycles. The counter is P_CNT_W bits, so the maximum pulse is 2^P_CNT_W - 1.
- Simultaneous events: a channel's natural pulse end and an accepted command to another channel act independently. Only one command per cycle.
- Back-to-back pulses: a new PULSE to the same channel is accepted in the first cycle its o_busy is low. This gives exactly one inactive cycle between the two pulses.
- Reset mid-pulse: outputs go immediately (asynchronously) to inactive levels and the counters clear.

Test Plan:
- Reset with P_ACTIVE_HIGH = 4'b0101: hold i_rst_n = 0 -> o_sig = 4'b1010, o_busy = 0, o_err = 0, o_cmd_ready = 1.
- ASSERT ch1 (active-LOW) at t -> o_sig[1] = 0 from t+1; TOGGLE ch1 -> o_sig[1] = 1; DEASSERT on an OFF channel -> no change, o_err = 0.
- PULSE ch0 with len = 5 -> o_sig[0] = 1 and o_busy[0] = 1 for exactly 5 cycles. A second PULSE to ch0 during the pulse sees ready = 0 and is accepted on the first cycle after busy drops. An ASSERT to ch2 in the same window is accepted immediately.
- PULSE ch3 len = 100, then DEASSERT ch3 after 10 cycles -> accepted while busy; o_sig[3] inactive and o_busy[3] = 0 on the next cycle.
- Illegal commands, with P_CHANNELS = 3: i_cmd_ch = 3 -> o_err high 1 cycle, o_sig unchanged. PULSE with len = 0 -> o_err high 1 cycle, no busy.
- PULSE len = 65535 with i_rst_n dropped at cycle 200 -> asynchronous return to reset values. After release, ASSERT works normally.
